// File: rtl/cnn_frame_ctrl_pkg.sv
// Shared CNN definitions: frame FSM encoding and fmap geometry helpers.
package cnn_frame_ctrl_pkg;

    // Frame sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } frame_state_e;

    // Default geometry of the network layer
    localparam int unsigned CNN_IX    = 28;
    localparam int unsigned CNN_IY    = 28;
    localparam int unsigned CNN_KX    = 5;
    localparam int unsigned CNN_KY    = 5;
    localparam int unsigned CNN_OX    = CNN_IX - CNN_KX + 1;
    localparam int unsigned CNN_OY    = CNN_IY - CNN_KY + 1;
    localparam int unsigned CNN_N_PIX = CNN_IX * CNN_IY;
    localparam int unsigned CNN_N_OUT = CNN_OX * CNN_OY;

    // Valid-convolution output dimension
    function automatic int unsigned cnn_out_dim(input int unsigned i_dim, input int unsigned k_dim);
        return i_dim - k_dim + 1;
    endfunction

    // Number of input pixels in a frame
    function automatic int unsigned cnn_n_pix(input int unsigned ix, input int unsigned iy);
        return ix * iy;
    endfunction

    // Number of output pixels in a frame
    function automatic int unsigned cnn_n_out(input int unsigned ix, input int unsigned iy,
                                              input int unsigned kx, input int unsigned ky);
        return cnn_out_dim(ix, kx) * cnn_out_dim(iy, ky);
    endfunction

endpackage

// File: rtl/cnn_frame_ctrl.sv
// Frame controller: streams one input fmap into an external convolution core
// and writes the core results to the output memory, with a drain timeout.
module cnn_frame_ctrl
    import cnn_frame_ctrl_pkg::*;
#(
    parameter int unsigned IX        = 28,
    parameter int unsigned IY        = 28,
    parameter int unsigned KX        = 5,
    parameter int unsigned KY        = 5,
    parameter int unsigned I_F_BW    = 8,
    parameter int unsigned CO        = 3,
    parameter int unsigned O_F_BW    = 20,
    parameter int unsigned DRAIN_MAX = 256
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic                   o_pix_rd_en,
    output logic [9:0]             o_pix_addr,
    input  logic [I_F_BW-1:0]      i_pix_data,
    output logic                   o_core_clr,
    output logic                   o_core_valid,
    output logic [I_F_BW-1:0]      o_core_fmap,
    input  logic                   i_core_valid,
    input  logic [CO*O_F_BW-1:0]   i_core_fmap,
    output logic                   o_ofm_we,
    output logic [9:0]             o_ofm_addr,
    output logic [CO*O_F_BW-1:0]   o_ofm_data
);

    localparam int unsigned N_PIX = cnn_n_pix(IX, IY);
    localparam int unsigned N_OUT = cnn_n_out(IX, IY, KX, KY);
    localparam int unsigned PIX_W = $clog2(N_PIX + 1);
    localparam int unsigned OUT_W = $clog2(N_OUT + 1);
    localparam int unsigned DRN_W = $clog2(DRAIN_MAX + 1);

    frame_state_e       r_state;
    frame_state_e       w_state_nxt;
    logic [PIX_W-1:0]   r_pix_cnt;
    logic [OUT_W-1:0]   r_out_cnt;
    logic [DRN_W-1:0]   r_drain_cnt;
    logic               r_err;
    logic               r_core_valid;

    logic               w_start;
    logic               w_active;
    logic               w_out_full;
    logic               w_wr;
    logic               w_out_reach;
    logic               w_last_pix;
    logic               w_drain_to;

    // Frame condition decode
    always_comb begin
        w_start     = (r_state == ST_IDLE) && i_start;
        w_active    = (r_state == ST_CLEAR) || (r_state == ST_FEED) || (r_state == ST_DRAIN);
        w_out_full  = (r_out_cnt == OUT_W'(N_OUT));
        w_wr        = i_core_valid && w_active && !w_out_full;
        w_out_reach = w_out_full || (w_wr && (r_out_cnt == OUT_W'(N_OUT - 1)));
        w_last_pix  = (r_pix_cnt == PIX_W'(N_PIX - 1));
        w_drain_to  = (r_drain_cnt == DRN_W'(DRAIN_MAX - 1));
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_CLEAR;
            ST_CLEAR: w_state_nxt = ST_FEED;
            ST_FEED:  if (w_last_pix) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_out_reach || w_drain_to) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State, counters, sticky error and pixel strobe pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pix_cnt    <= '0;
            r_out_cnt    <= '0;
            r_drain_cnt  <= '0;
            r_err        <= 1'b0;
            r_core_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_core_valid <= (r_state == ST_FEED);
            if (w_start) begin
                r_pix_cnt   <= '0;
                r_out_cnt   <= '0;
                r_drain_cnt <= '0;
                r_err       <= 1'b0;
            end else begin
                if (r_state == ST_FEED)
                    r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                if (w_wr)
                    r_out_cnt <= r_out_cnt + OUT_W'(1);
                if (r_state == ST_DRAIN)
                    r_drain_cnt <= r_drain_cnt + DRN_W'(1);
                // Timeout only counts as an error when the frame did not complete this cycle
                if ((r_state == ST_DRAIN) && !w_out_reach && w_drain_to)
                    r_err <= 1'b1;
            end
        end
    end

    // Output decode; write port is same-cycle with the core strobe
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = (r_state == ST_DONE);
    assign o_err        = r_err;
    assign o_core_clr   = (r_state == ST_CLEAR);
    assign o_pix_rd_en  = (r_state == ST_FEED);
    assign o_pix_addr   = (r_state == ST_FEED) ? 10'(r_pix_cnt) : 10'd0;
    assign o_core_valid = r_core_valid;
    assign o_core_fmap  = r_core_valid ? i_pix_data : '0;
    assign o_ofm_we     = w_wr;
    assign o_ofm_addr   = w_wr ? 10'(r_out_cnt) : 10'd0;
    assign o_ofm_data   = w_wr ? i_core_fmap : '0;

endmodule

// File: doc/cnn_frame_ctrl.md
CNN_FRAME_CTRL -- requirements
Module: cnn_frame_ctrl

Interface
REQ-001 The block SHALL have parameter IX, default 28, meaning input fmap width in pixels.
REQ-002 The block SHALL have parameter IY, default 28, meaning input fmap height in pixels.
REQ-003 The block SHALL have parameter KX, default 5, meaning kernel width.
REQ-004 The block SHALL have parameter KY, default 5, meaning kernel height.
REQ-005 The block SHALL have parameters I_F_BW = 8, CO = 3 and O_F_BW = 20, meaning pixel width, output channels and per-channel result width.
REQ-006 The block SHALL have parameter DRAIN_MAX, default 256, meaning cycle limit for the drain phase.
REQ-007 The block SHALL have the following ports, one per line:
clk  in  1  single clock; all logic rising-edge.
reset  in  1  synchronous, active-high reset.
i_start  in  1  frame start request.
o_busy  out  1  high in every state except IDLE.
o_done  out  1  one-cycle pulse at frame completion.
o_err  out  1  sticky drain-timeout flag, cleared by the next accepted i_start.
o_pix_rd_en  out  1  input pixel memory read enable.
o_pix_addr  out  10  pixel address, row-major, 0..IX*IY-1.
i_pix_data  in  I_F_BW  pixel data, valid one cycle after o_pix_rd_en.
o_core_clr  out  1  one-cycle clear of convolution core state (line buffer, accumulators).
o_core_valid  out  1  pixel strobe to the core.
o_core_fmap  out  I_F_BW  pixel to the core.
i_core_valid  in  1  core result strobe.
i_core_fmap  in  CO*O_F_BW  core result, CO packed channels.
o_ofm_we  out  1  output memory write enable.
o_ofm_addr  out  10  output address, 0..OX*OY-1.
o_ofm_data  out  CO*O_F_BW  output write data.

Function
REQ-008 OX = IX-KX+1 and OY = IY-KY+1 SHALL be derived; N_PIX = IX*IY; N_OUT = OX*OY (576 at defaults).
REQ-009 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN and DONE.
REQ-010 IDLE -> CLEAR SHALL occur when i_start = 1; on this transition o_err SHALL be cleared and the pixel and output counters zeroed.
REQ-011 i_start SHALL be ignored in every state other than IDLE.
REQ-012 CLEAR SHALL last exactly one cycle, assert o_core_clr and go to FEED.
REQ-013 FEED SHALL assert o_pix_rd_en every cycle with o_pix_addr = 0,1,...,N_PIX-1, with no gaps.
REQ-014 FEED SHALL go to DRAIN on the cycle after the read of address N_PIX-1.
REQ-015 o_core_valid SHALL be the one-cycle-delayed copy of o_pix_rd_en, and o_core_fmap SHALL equal i_pix_data in that cycle; the last pixel strobe therefore falls in the first DRAIN cycle.
REQ-016 Every i_core_valid in CLEAR, FEED or DRAIN with output count < N_OUT SHALL produce, in the same cycle: o_ofm_we = 1, o_ofm_addr = count, o_ofm_data = i_core_fmap. The count SHALL then increment by 1.
REQ-017 i_core_valid in IDLE or DONE, or when count = N_OUT, SHALL be ignored and SHALL produce no write.
REQ-018 DRAIN SHALL go to DONE when the count reaches N_OUT, including the cycle of the final write.
REQ-019 DRAIN SHALL also go to DONE, and set o_err, when DRAIN_MAX cycles elapse in DRAIN without the count reaching N_OUT.
REQ-020 DONE SHALL last one cycle with o_done = 1 and then go to IDLE; the earliest new i_start is accepted in the following IDLE cycle.
REQ-021 All counters SHALL be unsigned and sized to hold N_PIX and DRAIN_MAX without wrap; they SHALL never wrap during a frame.

Reset
REQ-022 While reset = 1 at a clock edge, the FSM SHALL go to IDLE and all counters SHALL clear.
REQ-023 All outputs SHALL be 0 after reset (o_busy, o_done, o_err, o_pix_rd_en, o_pix_addr, o_core_clr, o_core_valid, o_core_fmap, o_ofm_we, o_ofm_addr, o_ofm_data).
REQ-024 Reset in the middle of a frame SHALL abort it with no o_done pulse; any pipelined o_core_valid SHALL be dropped.

Structure
REQ-025 The state encoding and the derived constants OX, OY, N_PIX and N_OUT SHALL live in the shared CNN package.
REQ-026 The block SHALL be a single module with no sub-modules; the core and the memories are external.

Verification
REQ-027 Reset then i_start at cycle 0 SHALL give o_core_clr at cycle 1, o_pix_rd_en with address 0 at cycle 2, o_core_valid at cycle 3, and address 783 at cycle 785.
REQ-028 A core model returning 576 strobes SHALL produce 576 writes at addresses 0..575 with data matching, followed by exactly one o_done pulse and o_err = 0.
REQ-029 A core model returning only 575 strobes SHALL give o_done exactly DRAIN_MAX = 256 cycles after DRAIN entry, with o_err = 1; the next accepted i_start SHALL clear o_err.
REQ-030 Injecting 3 extra strobes after the 576th, and strobes while in IDLE, SHALL produce no writes.
REQ-031 i_start pulsed during FEED SHALL have no effect; reset asserted at pixel 400 SHALL return all outputs to 0 with no o_done pulse.
